// File: rtl/uart_beacon_if.sv
// Byte-stream bundle between uart_beacon and the UART rx/tx blocks.
// master is the beacon side (produces the tx stream); slave is the UART side.
interface uart_beacon_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  rx_byte,
        input  rx_valid,
        input  tx_ready,
        output tx_byte,
        output tx_valid
    );

    modport slave (
        output rx_byte,
        output rx_valid,
        output tx_ready,
        input  tx_byte,
        input  tx_valid
    );
endinterface

// File: rtl/uart_beacon.sv
// Byte source for the UART transmit path: periodic character bursts (beacon)
// or single-entry echo of received bytes, with valid/ready back-pressure.
module uart_beacon #(
    parameter int unsigned PERIOD_CYCLES = 12_000_000,
    parameter int unsigned CNT_W         = 24,
    parameter logic [7:0]  FIRST_CHAR    = 8'h30,
    parameter logic [7:0]  LAST_CHAR     = 8'h39,
    parameter int unsigned BURST_LEN     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    uart_beacon_if.master bus,
    output logic          led,
    output logic          overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [7:0]       BURST_LAST = 8'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       next_char_q, next_char_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             echo_q, echo_d;
    logic             led_q, led_d;
    logic             overrun_q, overrun_d;

    logic             tick;
    logic             eff_echo;
    logic             drain;
    logic [7:0]       char_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_byte_q   <= 8'h00;
            next_char_q <= FIRST_CHAR;
            burst_cnt_q <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            echo_q      <= 1'b0;
            led_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_byte_q   <= tx_byte_d;
            next_char_q <= next_char_d;
            burst_cnt_q <= burst_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            echo_q      <= echo_d;
            led_q       <= led_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_byte_d   = tx_byte_q;
        next_char_d = next_char_q;
        burst_cnt_d = burst_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        echo_d      = echo_q;
        led_d       = led_q;
        overrun_d   = overrun_q;
        drain       = 1'b0;

        tick     = (cnt_q == CNT_LAST);
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        char_adv = (next_char_q == LAST_CHAR) ? FIRST_CHAR : next_char_q + 8'd1;
        // A burst in flight keeps the mode it started with; mode is only live in IDLE.
        eff_echo = (state_q == IDLE) ? mode : echo_q;

        case (state_q)
            IDLE: begin
                if (!mode && tick) begin
                    tx_byte_d   = next_char_q;
                    burst_cnt_d = BURST_LAST;
                    echo_d      = 1'b0;
                    led_d       = ~led_q;
                    state_d     = SEND;
                end else if (mode && hold_full_q) begin
                    tx_byte_d   = hold_q;
                    hold_full_d = 1'b0;
                    drain       = 1'b1;
                    echo_d      = 1'b1;
                    led_d       = ~led_q;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (!echo_q && tick) begin
                    overrun_d = 1'b1;
                end
                if (bus.tx_ready) begin
                    if (echo_q) begin
                        state_d = IDLE;
                    end else begin
                        next_char_d = char_adv;
                        if (burst_cnt_q != 8'h00) begin
                            tx_byte_d   = char_adv;
                            burst_cnt_d = burst_cnt_q - 8'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The holder may refill in the same cycle it is drained into tx_byte.
        if (eff_echo && bus.rx_valid) begin
            if (!hold_full_q || drain) begin
                hold_d      = bus.rx_byte;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign bus.tx_byte  = tx_byte_q;
    assign bus.tx_valid = (state_q == SEND);
    assign led          = led_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/uart_beacon.md
Name: uart_beacon

Overview:
- Parametrised byte-stream source for the UART transmit path on the iCEstick build.
- Beacon mode: every PERIOD_CYCLES, emits a burst of BURST_LEN bytes from a wrapping character sequence (FIRST_CHAR..LAST_CHAR).
- Echo mode: returns each received byte through a one-entry holding register.
- Sits between uart_rx/uart_tx and the board LED. Uses a valid/ready handshake, so the transmitter back-pressures the stream.

Parameters:
- PERIOD_CYCLES, 12_000_000: clocks between beacon ticks (1 s at 12 MHz); must be >= 2.
- CNT_W, 24: period counter width; must satisfy 2**CNT_W > PERIOD_CYCLES.
- FIRST_CHAR, 8'h30: first character of the sequence ("0").
- LAST_CHAR, 8'h39: last character of the sequence ("9"); must be >= FIRST_CHAR.
- BURST_LEN, 1: bytes per beacon tick, 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = beacon, 1 = echo; sampled only in IDLE.
- rx_byte  in  8  received byte.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- tx_byte  out  8  byte to transmit.
- tx_valid  out  1  tx_byte is valid; held until accepted.
- tx_ready  in  1  transmitter can accept; transfer occurs when tx_valid && tx_ready on a rising edge.
- led  out  1  toggles at the start of each beacon burst and on each echoed byte.
- overrun  out  1  sticky; set on a dropped tick or dropped rx byte.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low. All state updates on posedge clk.
- Reset values: tx_byte=8'h00, tx_valid=0, led=0, overrun=0, period counter=0, next_char=FIRST_CHAR, burst_cnt=0, hold_full=0, state=IDLE.
- Period counter:
  - Free-runs 0..PERIOD_CYCLES-1, then wraps to 0, in both modes.
  - tick = (counter==PERIOD_CYCLES-1).
- States:
  - IDLE: tx_valid=0.
    - Beacon mode, tick: load tx_byte=next_char, burst_cnt=BURST_LEN-1, tx_valid=1, toggle led, go to SEND.
    - Echo mode, hold_full: tx_byte=hold, clear hold_full, tx_valid=1, toggle led, go to SEND.
  - SEND: tx_valid=1; tx_byte held stable until a transfer.
    - On a beacon-byte transfer: next_char advances (LAST_CHAR wraps to FIRST_CHAR).
      - burst_cnt!=0: tx_byte=advanced char, burst_cnt-1, stay in SEND (back-to-back; tx_valid stays high).
      - burst_cnt==0: go to IDLE.
    - On an echo-byte transfer: go to IDLE.
- Latency:
  - Tick at cycle N gives tx_valid=1 at N+1.
  - rx_valid at N with an empty holder: hold_full at N+1, tx_valid at N+2.
- Beacon mode:
  - rx_valid is ignored.
  - A tick while in SEND is dropped and sets overrun; the burst continues unaffected.
- Echo mode:
  - Ticks are ignored (no overrun).
  - rx_valid && !hold_full: capture rx_byte into the holder.
  - rx_valid && hold_full: drop the byte, set overrun, holder unchanged.
  - Capture and drain in the same cycle are allowed (holder refills).
- Mode change:
  - mode is sampled only in IDLE; a burst in progress completes in its starting mode.
  - Holder contents persist across a mode change and drain on the next echo-mode IDLE.
- next_char persists across bursts and mode changes; it is reset only by rst_n.
- Reset mid-burst: outputs return to reset values on the next edge; the interrupted byte is abandoned.
- overrun clears only on reset.

Test Plan (PERIOD_CYCLES=10, BURST_LEN=3, FIRST_CHAR=8'h30, LAST_CHAR=8'h32, unless noted):
- Reset release, tx_ready=1, mode=0 → first tx_valid at cycle 10 after reset. Bytes 30,31,32 on consecutive cycles. led=1. Next burst starts at cycle 20 with 30,31,32 (wrap).
- tx_ready=0 for 15 cycles from the first tx_valid → tx_byte stays 30, tx_valid stays 1. Tick during the stall sets overrun=1. Release → 31, 32 delivered, no byte lost or duplicated.
- BURST_LEN=1, LAST_CHAR=8'h39, tx_ready=1 → ten ticks yield 30..39, eleventh yields 30. led toggles each tick.
- mode=1, rx_valid with 8'h41, tx_ready=1 → tx_byte=41, tx_valid two cycles later for exactly one cycle. led toggles. Ticks produce nothing.
- mode=1, tx_ready=0, rx strobes 41 then 42 then 43 → holder drains 41 into tx; 42 is captured; 43 is dropped and overrun=1. Release ready → 41 then 42 transmitted.
- rst_n=0 for one cycle mid-burst (after 31 accepted) → tx_valid=0, led=0, overrun=0 next cycle. Next burst starts at 30.
